uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 146 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Four-channel round-robin arbiter in front of a single async_transmitter.
// A byte is accepted on req_valid & req_ready in IDLE. TxD_start follows one cycle later. req_ready stays low until the arbiter is back in IDLE.
module uart_tx_arbiter #(
    parameter int BUSY_TIMEOUT = 16,
    parameter int DONE_GAP     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    output logic [3:0]  req_ready,
    output logic        TxD_start,
    output logic [7:0]  TxD_data,
    input  logic        TxD_busy,
    output logic [1:0]  grant_id,
    output logic        busy_o,
    output logic        tx_done,
    output logic        err_timeout
);

    localparam int CNT_MAX = (BUSY_TIMEOUT > DONE_GAP) ? BUSY_TIMEOUT : DONE_GAP;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } state_t;

    state_t            stateQ, stateD;
    logic [CNT_W-1:0]  cntQ, cntD;
    logic [1:0]        lastGrantQ;
    logic [7:0]        txDataQ;
    logic [1:0]        grantIdQ;

    logic [1:0]        winner;
    logic              anyValid;
    logic              accept;
    logic [3:0]        reqReadyC;
    logic              txStartC;
    logic              txDoneC;
    logic              errTimeoutC;
    logic              busyLast;
    logic              gapLast;

    // Scan upward from the channel after the last grant; the last-granted channel is checked last.
    always_comb begin
        winner   = lastGrantQ;
        anyValid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!anyValid && req_valid[lastGrantQ + 2'(k)]) begin
                winner   = lastGrantQ + 2'(k);
                anyValid = 1'b1;
            end
        end
    end

    assign busyLast = (cntQ == CNT_W'(BUSY_TIMEOUT - 1));
    assign gapLast  = (DONE_GAP <= 1) || (cntQ == CNT_W'(DONE_GAP - 1));

    always_comb begin
        stateD      = stateQ;
        cntD        = cntQ;
        reqReadyC   = 4'b0000;
        accept      = 1'b0;
        txStartC    = 1'b0;
        txDoneC     = 1'b0;
        errTimeoutC = 1'b0;
        case (stateQ)
            IDLE: begin
                cntD = '0;
                if (anyValid) begin
                    reqReadyC[winner] = 1'b1;
                    accept            = 1'b1;
                    stateD            = START;
                end
            end
            START: begin
                txStartC = 1'b1;
                cntD     = '0;
                stateD   = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (TxD_busy) begin
                    cntD   = '0;
                    stateD = WAIT_DONE;
                end else if (busyLast) begin
                    errTimeoutC = 1'b1;
                    cntD        = '0;
                    stateD      = GAP;
                end else begin
                    cntD = cntQ + 1'b1;
                end
            end
            WAIT_DONE: begin
                cntD = '0;
                if (!TxD_busy) begin
                    txDoneC = 1'b1;
                    stateD  = GAP;
                end
            end
            GAP: begin
                if (gapLast) begin
                    cntD   = '0;
                    stateD = IDLE;
                end else begin
                    cntD = cntQ + 1'b1;
                end
            end
            default: begin
                cntD   = '0;
                stateD = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ     <= IDLE;
            cntQ       <= '0;
            lastGrantQ <= 2'd3;
            txDataQ    <= 8'h00;
            grantIdQ   <= 2'd0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            if (accept) begin
                txDataQ    <= req_data[{winner, 3'b000} +: 8];
                grantIdQ   <= winner;
                lastGrantQ <= winner;
            end
        end
    end

    // The combinational ready path is masked while reset is held so nothing looks accepted.
    assign req_ready   = rst_n ? reqReadyC : 4'b0000;
    assign TxD_start   = txStartC;
    assign TxD_data    = txDataQ;
    assign grant_id    = grantIdQ;
    assign busy_o      = (stateQ != IDLE);
    assign tx_done     = txDoneC;
    assign err_timeout = errTimeoutC;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small behavioural transmitter on TxD_busy.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        TxD_start;
    logic [7:0]  TxD_data;
    logic        TxD_busy;
    logic [1:0]  grant_id;
    logic        busy_o;
    logic        tx_done;
    logic        err_timeout;

    uart_tx_arbiter #(.BUSY_TIMEOUT(16), .DONE_GAP(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .TxD_start   (TxD_start),
        .TxD_data    (TxD_data),
        .TxD_busy    (TxD_busy),
        .grant_id    (grant_id),
        .busy_o      (busy_o),
        .tx_done     (tx_done),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int startCount = 0;
    int overlapCount = 0;

    // Transmitter model: busy rises two cycles after the start pulse and stays up for five.
    logic busyEn = 1'b1;
    int   delayCnt = 0;
    int   lenCnt = 0;
    initial TxD_busy = 1'b0;
    always @(negedge clk) begin
        if (TxD_start) begin
            if (busyEn) delayCnt = 2;
        end else if (delayCnt > 0) begin
            delayCnt = delayCnt - 1;
            if (delayCnt == 0) begin
                TxD_busy = 1'b1;
                lenCnt   = 5;
            end
        end else if (lenCnt > 0) begin
            lenCnt = lenCnt - 1;
            if (lenCnt == 0) TxD_busy = 1'b0;
        end
    end

    always begin
        @(negedge clk);
        #1;
        if (TxD_start) begin
            startCount = startCount + 1;
            if (TxD_busy) overlapCount = overlapCount + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic waitReady(input logic [3:0] v, input logic [31:0] d,
                             input logic [1:0] g, input logic [7:0] b, input string tag);
        logic       got;
        logic [3:0] oneHot;
        req_valid = v;
        req_data  = d;
        got       = 1'b0;
        oneHot    = 4'b0001 << g;
        for (int i = 0; i < 60 && !got; i++) begin
            #1;
            if (req_ready != 4'b0000) got = 1'b1;
            else @(negedge clk);
        end
        check({tag, "_ready_seen"}, 64'(got), 64'd1);
        if (got) begin
            check({tag, "_ready"}, 64'(req_ready), 64'(oneHot));
            @(posedge clk);
            @(negedge clk);
            #1;
            check({tag, "_start"}, 64'({TxD_start, busy_o, req_ready}), 64'({1'b1, 1'b1, 4'b0000}));
            check({tag, "_data"}, 64'({grant_id, TxD_data}), 64'({g, b}));
        end
    endtask

    task automatic waitDone(input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            #1;
            if (tx_done || err_timeout) got = 1'b1;
        end
        check({tag, "_done"}, 64'({got, tx_done, err_timeout}), 64'(3'b110));
    endtask

    task automatic waitBusyHigh(input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            #1;
            if (TxD_busy) got = 1'b1;
        end
        check({tag, "_busy_rose"}, 64'(got), 64'd1);
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [1:0]  expGrant;
        logic [7:0]  expData;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic got;
        logic sawDone;
        logic sawPulse;
        int   c;

        vecs[0] = '{4'b1111, 32'hA3A2A1A0, 2'd0, 8'hA0};
        vecs[1] = '{4'b1111, 32'hA3A2A1A0, 2'd1, 8'hA1};
        vecs[2] = '{4'b1111, 32'hA3A2A1A0, 2'd2, 8'hA2};
        vecs[3] = '{4'b1111, 32'hA3A2A1A0, 2'd3, 8'hA3};
        vecs[4] = '{4'b1111, 32'hA3A2A1A0, 2'd0, 8'hA0};
        vecs[5] = '{4'b0001, 32'h0000002F, 2'd0, 8'h2F};
        vecs[6] = '{4'b1000, 32'h5C000000, 2'd3, 8'h5C};
        vecs[7] = '{4'b1010, 32'h33001100, 2'd1, 8'h11};
        vecs[8] = '{4'b0110, 32'h00664400, 2'd2, 8'h66};
        vecs[9] = '{4'b0011, 32'h00008877, 2'd0, 8'h77};

        rst_n     = 1'b0;
        req_valid = 4'b0000;
        req_data  = 32'h0;
        #1;
        check("reset_outputs", 64'({req_ready, TxD_start, TxD_data, grant_id, busy_o, tx_done, err_timeout}), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            waitReady(vecs[i].valid, vecs[i].data, vecs[i].expGrant, vecs[i].expData, $sformatf("vec%0d", i));
            waitDone($sformatf("vec%0d", i));
        end

        busyEn = 1'b0;
        waitReady(4'b0100, 32'h00C30000, 2'd2, 8'hC3, "tmo");
        req_valid = 4'b0000;
        got = 1'b0;
        sawDone = 1'b0;
        c = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            #1;
            c = c + 1;
            if (tx_done) sawDone = 1'b1;
            if (err_timeout) got = 1'b1;
        end
        check("tmo_cycles", 64'(c), 64'd16);
        check("tmo_pulse", 64'({got, sawDone}), 64'(2'b10));
        @(negedge clk);
        #1;
        check("tmo_one_cycle", 64'({err_timeout, busy_o}), 64'(2'b01));
        busyEn = 1'b1;

        waitReady(4'b1101, 32'hD3D200D0, 2'd3, 8'hD3, "after_tmo");
        waitDone("after_tmo");

        waitReady(4'b0110, 32'h00422100, 2'd1, 8'h21, "glitch");
        req_valid = 4'b0100;
        waitBusyHigh("glitch");
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        check("glitch_low", 64'({req_ready, TxD_data, grant_id}), 64'({4'b0000, 8'h21, 2'd1}));
        @(negedge clk);
        req_valid = 4'b0100;
        #1;
        check("glitch_back", 64'({req_ready, TxD_data, grant_id}), 64'({4'b0000, 8'h21, 2'd1}));
        waitDone("glitch");

        waitReady(4'b0100, 32'h00422100, 2'd2, 8'h42, "rst");
        waitBusyHigh("rst");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", 64'({req_ready, TxD_start, TxD_data, grant_id, busy_o, tx_done, err_timeout}), 64'd0);
        sawPulse = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            #1;
            if (tx_done || err_timeout || busy_o) sawPulse = 1'b1;
            if (!TxD_busy) got = 1'b1;
        end
        check("rst_hold_quiet", 64'({got, sawPulse}), 64'(2'b10));
        @(negedge clk);
        rst_n = 1'b1;
        waitReady(4'b1111, 32'hB3B2B1B0, 2'd0, 8'hB0, "post_rst");
        waitDone("post_rst");
        req_valid = 4'b0000;

        repeat (5) @(negedge clk);
        #1;
        check("start_count", 64'(startCount), 64'd15);
        check("start_overlap", 64'(overlapCount), 64'd0);
        check("final_idle", 64'({busy_o, req_ready}), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
